aes_input_packer: RTL and testbench

- Sits directly upstream of AES stage 0 in the cohort FIFO-controller accelerator unit.
- Consumes 64-bit words from the consumer FIFO and assembles them into one 256-bit stage-0 input beat: plaintext[127:0] and key[127:0].
- Optional sticky-key mode holds the key across blocks, so each subsequent block needs only two plaintext words.
- Assembly and output are decoupled, so gathering of block N+1 overlaps the output stall of block N.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_beat_reg.sv | 56 +++++
 rtl/aes_input_packer.sv | 143 ++++++++++++++
 tb/tb_aes_input_packer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types for the AES stage-0 front end.
//   aes_pack_state_e  : input packer gather FSM states
//   AES_BLK_W         : AES state / key width
//   aes_stage0_beat_t : one stage-0 input beat, {key, pt}
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [2:0] {
        PT0,
        PT1,
        K0,
        K1,
        FULL
    } aes_pack_state_e;

    typedef struct packed {
        logic [AES_BLK_W-1:0] key;
        logic [AES_BLK_W-1:0] pt;
    } aes_stage0_beat_t;

endpackage

// File: rtl/aes_beat_reg.sv
// Single-entry valid/ready output register. It holds its data while stalled
// and can take a new beat in the same cycle the current one drains, so it
// sustains one beat per cycle.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : load side
//   in_data [W]          : beat to load
//   out_valid/out_ready  : drain side
//   out_data [W]         : registered beat, stable while stalled
module aes_beat_reg
    import aes_pkg::*;
#(
    parameter int W = 2 * AES_BLK_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    // Empty, or the held beat leaves this cycle.
    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/aes_input_packer.sv
// Gathers 64-bit words from the consumer FIFO into one 256-bit AES stage-0
// beat {key, plaintext}. Word order PT0, PT1, K0, K1 (low half first).
// In sticky-key mode the key is kept and later blocks need only PT0/PT1.
// A completed block goes straight into the output register when it can take
// it; otherwise it waits in FULL, which is the only state stalling input.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : upstream word handshake, in_data [WORD_W]
//   key_sticky          : retain key after K1 completion
//   key_flush           : pulse, drop held key
//   out_valid/out_ready : stage-0 beat handshake, out_data [2*BLK_W]
//   blocks_out [CNT_W]  : beats accepted by stage 0 (wraps)
//   busy                : partial block held or beat pending
module aes_input_packer
    import aes_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int BLK_W  = 2 * WORD_W,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               key_sticky,
    input  logic               key_flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*BLK_W-1:0] out_data,
    output logic [CNT_W-1:0]   blocks_out,
    output logic               busy
);

    aes_pack_state_e  state_q, state_d;
    logic [BLK_W-1:0] pt_q, pt_d;
    logic [BLK_W-1:0] key_q, key_d;
    logic             key_held_q, key_held_d;
    logic             flush_pend_q, flush_pend_d;
    logic             alive_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             xfer;
    logic             complete;
    logic             beat_vld, beat_rdy;
    aes_stage0_beat_t beat;

    // alive_q keeps in_ready low while reset is asserted.
    assign in_ready = alive_q && (state_q != FULL);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        pt_d         = pt_q;
        key_d        = key_q;
        key_held_d   = key_held_q;
        flush_pend_d = flush_pend_q;
        complete     = 1'b0;

        if (key_flush) key_held_d = 1'b0;

        case (state_q)
            PT0: if (xfer) begin
                pt_d[WORD_W-1:0] = in_data;
                state_d          = PT1;
            end
            PT1: if (xfer) begin
                pt_d[BLK_W-1:WORD_W] = in_data;
                // A coincident flush forces a fresh key.
                if (key_held_q && !key_flush) complete = 1'b1;
                else                          state_d  = K0;
            end
            K0: begin
                // Flush during key gather: the incoming key is used for this
                // block but not retained afterwards.
                if (key_flush) flush_pend_d = 1'b1;
                if (xfer) begin
                    key_d[WORD_W-1:0] = in_data;
                    state_d           = K1;
                end
            end
            K1: begin
                if (key_flush) flush_pend_d = 1'b1;
                if (xfer) begin
                    key_d[BLK_W-1:WORD_W] = in_data;
                    complete              = 1'b1;
                    key_held_d            = key_sticky && !key_flush && !flush_pend_q;
                    flush_pend_d          = 1'b0;
                end
            end
            FULL: ;
            default: state_d = PT0;
        endcase

        // Completed (this cycle or earlier) block heads for the output register.
        beat_vld = complete || (state_q == FULL);
        if (beat_vld) state_d = beat_rdy ? PT0 : FULL;

        cnt_d = cnt_q;
        if (out_valid && out_ready) cnt_d = cnt_q + 1'b1;
    end

    // Built from the next-state buffers so the last word bypasses into the beat.
    always_comb begin
        beat     = '0;
        beat.key = key_d;
        beat.pt  = pt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PT0;
            pt_q         <= '0;
            key_q        <= '0;
            key_held_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            alive_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pt_q         <= pt_d;
            key_q        <= key_d;
            key_held_q   <= key_held_d;
            flush_pend_q <= flush_pend_d;
            alive_q      <= 1'b1;
            cnt_q        <= cnt_d;
        end
    end

    aes_beat_reg #(.W(2 * BLK_W)) u_beat_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (beat_vld),
        .in_ready  (beat_rdy),
        .in_data   (beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign blocks_out = cnt_q;
    assign busy       = (state_q != PT0) || out_valid;

endmodule

// File: tb/tb_aes_input_packer.sv
module tb_aes_input_packer;

    logic         clk, rst_n;
    logic         in_valid, in_ready;
    logic [63:0]  in_data;
    logic         key_sticky, key_flush;
    logic         out_valid, out_ready;
    logic [255:0] out_data;
    logic [31:0]  blocks_out;
    logic         busy;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int xfers = 0;
    int drops = 0;
    logic trk = 1'b0;
    logic [255:0] bq[$];
    int           bc[$];

    aes_input_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .key_sticky (key_sticky),
        .key_flush  (key_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .blocks_out (blocks_out),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe handshakes 1 time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        cyc++;
        if (rst_n && in_valid && in_ready) xfers++;
        if (trk && !in_ready) drops++;
        if (rst_n && out_valid && out_ready) begin
            bq.push_back(out_data);
            bc.push_back(cyc);
        end
    end

    function automatic logic [255:0] pop_beat();
        logic [255:0] b;
        b = '0;
        if (bq.size() > 0) b = bq.pop_front();
        return b;
    endfunction

    function automatic int pop_cyc();
        int c;
        c = -1;
        if (bc.size() > 0) c = bc.pop_front();
        return c;
    endfunction

    // Present one word at a negedge; return at the negedge after it transfers.
    task automatic send(input logic [63:0] d, input logic fl);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        key_flush = fl;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            nvec++; nerr++;
            $display("FAIL send_timeout word=%h in_ready stayed 0", d);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        key_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        key_sticky = 1'b0; key_flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        nvec++; if (out_data !== 256'h0) begin nerr++; $display("FAIL rst_out_data got %h want 0", out_data); end
        nvec++; if (blocks_out !== 32'h0) begin nerr++; $display("FAIL rst_blocks got %h want 0", blocks_out); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [255:0] exp;
        exp = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
        bq.delete(); bc.delete();
        send(64'h1111, 1'b0);
        send(64'h2222, 1'b0);
        send(64'h3333, 1'b0);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        send(64'h4444, 1'b0);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL basic_latency out_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== exp) begin nerr++; $display("FAIL basic_data got %h want %h", out_data, exp); end
        @(negedge clk);
        nvec++; if (blocks_out !== 32'd1) begin nerr++; $display("FAIL basic_blocks got %0d want 1", blocks_out); end
        nvec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin nerr++; $display("FAIL basic_idle busy=%b out_valid=%b want 0/0", busy, out_valid); end
    endtask

    task automatic test_sticky();
        logic [255:0] b;
        bq.delete(); bc.delete();
        key_sticky = 1'b1;
        xfers = 0; drops = 0; trk = 1'b1;
        send(64'h10, 1'b0); send(64'h11, 1'b0);
        send(64'hC0, 1'b0); send(64'hC1, 1'b0);
        send(64'h20, 1'b0); send(64'h21, 1'b0);
        @(negedge clk);
        trk = 1'b0;
        b = pop_beat();
        nvec++; if (b !== {64'hC1, 64'hC0, 64'h11, 64'h10}) begin nerr++; $display("FAIL sticky_beat1 got %h", b); end
        b = pop_beat();
        nvec++; if (b !== {64'hC1, 64'hC0, 64'h21, 64'h20}) begin nerr++; $display("FAIL sticky_beat2 got %h want key C1C0 pt 2120", b); end
        nvec++; if (xfers !== 6) begin nerr++; $display("FAIL sticky_xfers got %0d want 6", xfers); end
        nvec++; if (drops !== 0) begin nerr++; $display("FAIL sticky_ready_drop got %0d cycles want 0", drops); end
        nvec++; if (blocks_out !== 32'd3) begin nerr++; $display("FAIL sticky_blocks got %0d want 3", blocks_out); end
    endtask

    task automatic test_stall();
        logic [255:0] b1, b2, b;
        int c1, c2;
        b1 = {64'h34, 64'h33, 64'h32, 64'h31};
        b2 = {64'h44, 64'h43, 64'h42, 64'h41};
        // drop the held key so blocks take four words again
        key_sticky = 1'b0; key_flush = 1'b1;
        @(negedge clk);
        key_flush = 1'b0;
        bq.delete(); bc.delete();
        out_ready = 1'b0;
        send(64'h31, 1'b0); send(64'h32, 1'b0); send(64'h33, 1'b0); send(64'h34, 1'b0);
        send(64'h41, 1'b0); send(64'h42, 1'b0); send(64'h43, 1'b0); send(64'h44, 1'b0);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL stall_full_ready got %b want 0", in_ready); end
        repeat (12) @(negedge clk);
        nvec++; if (out_valid !== 1'b1 || out_data !== b1) begin nerr++; $display("FAIL stall_hold v=%b data=%h want %h", out_valid, out_data, b1); end
        nvec++; if (bq.size() !== 0) begin nerr++; $display("FAIL stall_leak got %0d beats want 0", bq.size()); end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        b = pop_beat(); c1 = pop_cyc();
        nvec++; if (b !== b1) begin nerr++; $display("FAIL stall_first got %h want %h", b, b1); end
        b = pop_beat(); c2 = pop_cyc();
        nvec++; if (b !== b2) begin nerr++; $display("FAIL stall_second got %h want %h", b, b2); end
        nvec++; if (c1 < 0 || c2 !== c1 + 1) begin nerr++; $display("FAIL stall_b2b cycles %0d,%0d want consecutive", c1, c2); end
        nvec++; if (blocks_out !== 32'd5 || busy !== 1'b0) begin nerr++; $display("FAIL stall_end blocks=%0d busy=%b want 5/0", blocks_out, busy); end
    endtask

    task automatic test_flush();
        logic [255:0] b;
        bq.delete(); bc.delete();
        key_sticky = 1'b1;
        send(64'h51, 1'b0); send(64'h52, 1'b0); send(64'h5A, 1'b0); send(64'h5B, 1'b0);
        send(64'h61, 1'b0);
        send(64'h62, 1'b1);
        nvec++; if (out_valid !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL flush_no_beat v=%b busy=%b want 0/1", out_valid, busy); end
        send(64'h6A, 1'b0); send(64'h6B, 1'b0);
        @(negedge clk);
        b = pop_beat();
        nvec++; if (b !== {64'h5B, 64'h5A, 64'h52, 64'h51}) begin nerr++; $display("FAIL flush_beat1 got %h", b); end
        b = pop_beat();
        nvec++; if (b !== {64'h6B, 64'h6A, 64'h62, 64'h61}) begin nerr++; $display("FAIL flush_newkey got %h want key 6B6A", b); end
        nvec++; if (blocks_out !== 32'd7) begin nerr++; $display("FAIL flush_blocks got %0d want 7", blocks_out); end
        key_sticky = 1'b0; key_flush = 1'b1;
        @(negedge clk);
        key_flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [255:0] b;
        send(64'h71, 1'b0); send(64'h72, 1'b0); send(64'h73, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bq.delete(); bc.delete();
        @(negedge clk);
        nvec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL rstmid_idle v=%b busy=%b want 0/0", out_valid, busy); end
        nvec++; if (blocks_out !== 32'd0) begin nerr++; $display("FAIL rstmid_blocks got %0d want 0", blocks_out); end
        send(64'h81, 1'b0); send(64'h82, 1'b0); send(64'h83, 1'b0); send(64'h84, 1'b0);
        @(negedge clk);
        b = pop_beat();
        nvec++; if (b !== {64'h84, 64'h83, 64'h82, 64'h81}) begin nerr++; $display("FAIL rstmid_beat got %h", b); end
        nvec++; if (bq.size() !== 0) begin nerr++; $display("FAIL rstmid_extra got %0d extra beats want 0", bq.size()); end
        nvec++; if (blocks_out !== 32'd1) begin nerr++; $display("FAIL rstmid_count got %0d want 1", blocks_out); end
    endtask

    task automatic test_wrap();
        force dut.cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt_q;
        nvec++; if (blocks_out !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL wrap_preload got %h want ffffffff", blocks_out); end
        send(64'h91, 1'b0); send(64'h92, 1'b0); send(64'h93, 1'b0); send(64'h94, 1'b0);
        @(negedge clk);
        nvec++; if (blocks_out !== 32'h0) begin nerr++; $display("FAIL wrap_count got %h want 0", blocks_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sticky();
        test_stall();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
